// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-operand ALU sequencer: opcodes, FSM states,
// CCR bit positions, unit-enable positions and the shift-step counter width.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MOV = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_ILL = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int CCR_C = 2;
  localparam int CCR_N = 1;
  localparam int CCR_Z = 0;

  localparam int UNIT_EN_W = 7;
  localparam int EN_MOV    = 0;
  localparam int EN_ADD    = 1;
  localparam int EN_SUB    = 2;
  localparam int EN_AND    = 3;
  localparam int EN_OR     = 4;
  localparam int EN_SHL    = 5;
  localparam int EN_SHR    = 6;

  localparam int STEP_W    = 5;
  localparam int SHIFT_MAX = 16;

  function automatic logic [UNIT_EN_W-1:0] unit_onehot(input opcode_e op);
    logic [UNIT_EN_W-1:0] en;
    en = '0;
    case (op)
      OP_MOV:  en[EN_MOV] = 1'b1;
      OP_ADD:  en[EN_ADD] = 1'b1;
      OP_SUB:  en[EN_SUB] = 1'b1;
      OP_AND:  en[EN_AND] = 1'b1;
      OP_OR:   en[EN_OR]  = 1'b1;
      OP_SHL:  en[EN_SHL] = 1'b1;
      OP_SHR:  en[EN_SHR] = 1'b1;
      default: en = '0;
    endcase
    return en;
  endfunction

  function automatic logic is_shift(input opcode_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_shift_stepper.sv
// Iterative shift support: accumulator, step counter, amount clamp and last-step flag.
// Optional feature macro: ALU_CTRL_SHIFT_CLAMP_EN (saturate amount at 16 instead of using shamt[3:0]).
module alu_shift_stepper
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] shamt,
  input  logic [WIDTH-1:0] unit_out,
  output logic [WIDTH-1:0] acc,
  output logic             amt_zero,
  output logic             last
);

  logic [STEP_W-1:0] amt;
  logic [STEP_W-1:0] count;

`ifdef ALU_CTRL_SHIFT_CLAMP_EN
  assign amt = (shamt >= WIDTH'(SHIFT_MAX)) ? STEP_W'(SHIFT_MAX) : shamt[STEP_W-1:0];
`else
  // Only shamt[3:0] matters here; the upper bits are deliberately dropped.
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^shamt[WIDTH-1:STEP_W-1];
  assign amt = {1'b0, shamt[STEP_W-2:0]};
`endif

  assign amt_zero = (amt == '0);
  assign last     = (count == STEP_W'(1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= rs_val;
      count <= amt;
    end else if (step) begin
      acc   <= unit_out;
      count <= count - STEP_W'(1);
    end
  end

endmodule

// File: rtl/two_op_alu_ctrl.sv
// Sequencer for the two-operand ALU units; owns the condition-code register.
// Optional feature macro: ALU_CTRL_SHIFT_CLAMP_EN (handled inside alu_shift_stepper).
module two_op_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     rs_val,
  input  logic [WIDTH-1:0]     rd_val,
  input  logic [WIDTH-1:0]     shamt,
  output logic [UNIT_EN_W-1:0] unit_en,
  output logic [WIDTH-1:0]     unit_rs,
  output logic [WIDTH-1:0]     unit_rd,
  output logic [WIDTH-1:0]     unit_shamt,
  output logic [FLAG_W-1:0]    unit_prev_flags,
  input  logic [WIDTH-1:0]     unit_out,
  input  logic [FLAG_W-1:0]    unit_ccr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic [FLAG_W-1:0]    ccr,
  output logic                 err
);

  state_e           state_q, state_d;
  opcode_e          op_q, op_in;
  logic [WIDTH-1:0] rs_q, rd_q, result_q, acc;
  logic [FLAG_W-1:0] ccr_q;
  logic             err_q;
  logic             accept, amt_zero, last_step;

  assign op_in  = opcode_e'(opcode);
  assign accept = (state_q == ST_IDLE) && in_valid;

  alu_shift_stepper #(.WIDTH(WIDTH)) u_stepper (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == ST_SHIFT),
    .rs_val   (rs_val),
    .shamt    (shamt),
    .unit_out (unit_out),
    .acc      (acc),
    .amt_zero (amt_zero),
    .last     (last_step)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unit_en    = '0;
    unit_rs    = '0;
    unit_rd    = '0;
    unit_shamt = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_in == OP_ILL)                   state_d = ST_DONE;
          else if (is_shift(op_in) && !amt_zero) state_d = ST_SHIFT;
          else                                   state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        unit_en = unit_onehot(op_q);
        unit_rs = rs_q;
        unit_rd = rd_q;
        state_d = ST_DONE;
      end
      ST_SHIFT: begin
        unit_en    = unit_onehot(op_q);
        unit_rs    = acc;
        unit_rd    = rd_q;
        unit_shamt = WIDTH'(1);
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOV;
      rs_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      ccr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          op_q  <= op_in;
          rs_q  <= rs_val;
          rd_q  <= rd_val;
          err_q <= (op_in == OP_ILL);
          // Illegal opcodes bypass the units and pass rd through untouched.
          if (op_in == OP_ILL) result_q <= rd_val;
        end
        ST_EXEC: begin
          result_q <= unit_out;
          ccr_q    <= unit_ccr;
        end
        ST_SHIFT: if (last_step) begin
          result_q <= unit_out;
          ccr_q    <= unit_ccr;
        end
        default: ;
      endcase
    end
  end

  assign unit_prev_flags = ccr_q;
  assign result          = result_q;
  assign ccr             = ccr_q;
  assign err             = err_q;

endmodule

// File: tb/tb_two_op_alu_ctrl.sv
// Self-checking bench for two_op_alu_ctrl: behavioural ALU units, directed table,
// reset-abort sequence and randomized instructions against a whole-instruction model.
module tb_two_op_alu_ctrl;

  localparam int WIDTH  = 16;
  localparam int FLAG_W = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        opcode = '0;
  logic [WIDTH-1:0]  rs_val = '0, rd_val = '0, shamt = '0;
  logic [6:0]        unit_en;
  logic [WIDTH-1:0]  unit_rs, unit_rd, unit_shamt;
  logic [FLAG_W-1:0] unit_prev_flags;
  logic [WIDTH-1:0]  unit_out;
  logic [FLAG_W-1:0] unit_ccr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  result;
  logic [FLAG_W-1:0] ccr;
  logic              err;

  int checks = 0;
  int failures = 0;
  logic [2:0] model_ccr = '0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] rs, rd, sh;
    int          hold;
    logic [15:0] r;
    logic [2:0]  c;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  two_op_alu_ctrl #(.WIDTH(WIDTH), .FLAG_W(FLAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs_val(rs_val), .rd_val(rd_val), .shamt(shamt),
    .unit_en(unit_en), .unit_rs(unit_rs), .unit_rd(unit_rd), .unit_shamt(unit_shamt),
    .unit_prev_flags(unit_prev_flags), .unit_out(unit_out), .unit_ccr(unit_ccr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ccr(ccr), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural function units: respond combinationally to whichever unit is enabled.
  logic [16:0] um_w;
  logic [31:0] um_t;
  logic        um_c;
  always_comb begin
    um_w     = '0;
    um_t     = '0;
    um_c     = unit_prev_flags[2];
    unit_out = '0;
    unit_ccr = unit_prev_flags;
    case (unit_en)
      7'b0000001: unit_out = unit_rs;
      7'b0000010: begin um_w = {1'b0, unit_rd} + {1'b0, unit_rs}; unit_out = um_w[15:0]; um_c = um_w[16]; end
      7'b0000100: begin unit_out = unit_rd - unit_rs; um_c = (unit_rd < unit_rs); end
      7'b0001000: begin unit_out = unit_rd & unit_rs; um_c = 1'b0; end
      7'b0010000: begin unit_out = unit_rd | unit_rs; um_c = 1'b0; end
      7'b0100000: begin
        um_t = {16'h0, unit_rs} << unit_shamt;
        unit_out = um_t[15:0];
        if (unit_shamt != 0) um_c = um_t[16];
      end
      7'b1000000: begin
        um_t = {unit_rs, 16'h0} >> unit_shamt;
        unit_out = um_t[31:16];
        if (unit_shamt != 0) um_c = um_t[15];
      end
      default: ;
    endcase
    if (unit_en != 7'b0 && unit_en != 7'b1)
      unit_ccr = {um_c, unit_out[15], unit_out == 16'h0};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_amt(input logic [15:0] sh);
`ifdef ALU_CTRL_SHIFT_CLAMP_EN
    return (sh > 16'd16) ? 16 : int'(sh);
`else
    return int'(sh % 16'd16);
`endif
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [15:0] rs, rd, sh, input int hold,
                              input logic [15:0] r, input logic [2:0] c, input logic e, input int lat);
    vec_t v;
    v.op = op; v.rs = rs; v.rd = rd; v.sh = sh; v.hold = hold;
    v.r = r; v.c = c; v.e = e; v.lat = lat;
    return v;
  endfunction

  // Whole-instruction reference: full shift computed in one go, flags from the final value.
  function automatic vec_t ref_model(input logic [2:0] op, input logic [15:0] rs, rd, sh,
                                     input logic [2:0] prev);
    vec_t v;
    logic [16:0] w;
    logic [31:0] t;
    logic cy;
    int n;
    v = mk(op, rs, rd, sh, 0, 16'h0, prev, 1'b0, 1);
    cy = prev[2];
    n = eff_amt(sh);
    case (op)
      3'd0: v.r = rs;
      3'd1: begin w = {1'b0, rd} + {1'b0, rs}; v.r = w[15:0]; cy = w[16]; end
      3'd2: begin v.r = rd - rs; cy = (rd < rs); end
      3'd3: begin v.r = rd & rs; cy = 1'b0; end
      3'd4: begin v.r = rd | rs; cy = 1'b0; end
      3'd5: begin
        t = {16'h0, rs} << n;
        v.r = t[15:0];
        if (n > 0) begin cy = t[16]; v.lat = n; end
      end
      3'd6: begin
        t = {rs, 16'h0} >> n;
        v.r = t[31:16];
        if (n > 0) begin cy = t[15]; v.lat = n; end
      end
      default: begin v.r = rd; v.e = 1'b1; v.lat = 0; end
    endcase
    if (op != 3'd0 && op != 3'd7) v.c = {cy, v.r[15], v.r == 16'h0};
    return v;
  endfunction

  // Issue one instruction from an IDLE negedge, check timing, unit drive, outputs, hold, consume.
  task automatic run_instr(input vec_t v, input string tag);
    int lat;
    logic drive_ok, stable;
    logic shift_path;
    logic [6:0] exp_en;
    logic [15:0] r0;
    logic [2:0] c0;
    logic e0;
    shift_path = (v.op == 3'd5 || v.op == 3'd6) && (eff_amt(v.sh) != 0);
    exp_en = (v.op == 3'd7) ? 7'b0 : (7'b1 << v.op);
    check({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; opcode = v.op; rs_val = v.rs; rd_val = v.rd; shamt = v.sh;
    @(negedge clk);
    in_valid = 1'b0; opcode = 3'($urandom); rs_val = 16'($urandom);
    rd_val = 16'($urandom); shamt = 16'($urandom);
    lat = 0;
    drive_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (unit_en !== exp_en || unit_shamt !== (shift_path ? 16'd1 : 16'd0) ||
          unit_prev_flags !== model_ccr) drive_ok = 1'b0;
      if (lat == 0 && unit_rs !== v.rs) drive_ok = 1'b0;
      if (!shift_path && unit_rd !== v.rd) drive_ok = 1'b0;
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " unit_drive"}, drive_ok, 1);
    check({tag, " result"}, result, v.r);
    check({tag, " ccr"}, ccr, v.c);
    check({tag, " err"}, err, v.e);
    check({tag, " done_ready_en"}, {in_ready, unit_en}, 8'h00);
    r0 = result; c0 = ccr; e0 = err;
    stable = 1'b1;
    for (int k = 0; k < v.hold; k++) begin
      in_valid = 1'b1; opcode = 3'd1; rs_val = 16'($urandom); rd_val = 16'($urandom);
      @(negedge clk);
      if (result !== r0 || ccr !== c0 || err !== e0 || out_valid !== 1'b1 ||
          in_ready !== 1'b0 || unit_en !== 7'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (v.hold > 0) check({tag, " hold_stable"}, stable, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " consumed"}, {out_valid, in_ready}, 2'b01);
    model_ccr = v.c;
  endtask

  initial begin
    vec_t v;
    logic [2:0] rop;
    logic [15:0] rsh;

    tbl[0]  = mk(3'd1, 16'h0001, 16'h7FFF, 16'h0000, 5, 16'h8000, 3'b010, 1'b0, 1);
    tbl[1]  = mk(3'd2, 16'h0005, 16'h0005, 16'h0000, 0, 16'h0000, 3'b001, 1'b0, 1);
    tbl[2]  = mk(3'd0, 16'h1234, 16'h0000, 16'h0000, 0, 16'h1234, 3'b001, 1'b0, 1);
    tbl[3]  = mk(3'd5, 16'h8001, 16'h0000, 16'h0003, 0, 16'h0008, 3'b000, 1'b0, 3);
`ifdef ALU_CTRL_SHIFT_CLAMP_EN
    tbl[4]  = mk(3'd6, 16'hFFFF, 16'h0000, 16'h0011, 0, 16'h0000, 3'b101, 1'b0, 16);
`else
    tbl[4]  = mk(3'd6, 16'hFFFF, 16'h0000, 16'h0011, 0, 16'h7FFF, 3'b100, 1'b0, 1);
`endif
    tbl[5]  = mk(3'd3, 16'h0F0F, 16'hFF00, 16'h0000, 0, 16'h0F00, 3'b000, 1'b0, 1);
    tbl[6]  = mk(3'd4, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 3'b001, 1'b0, 1);
    tbl[7]  = mk(3'd5, 16'h8000, 16'h0000, 16'h0000, 0, 16'h8000, 3'b010, 1'b0, 1);
    tbl[8]  = mk(3'd7, 16'h1111, 16'hABCD, 16'h0000, 2, 16'hABCD, 3'b010, 1'b1, 0);
`ifdef ALU_CTRL_SHIFT_CLAMP_EN
    tbl[9]  = mk(3'd5, 16'h0001, 16'h0000, 16'h0010, 0, 16'h0000, 3'b101, 1'b0, 16);
`else
    tbl[9]  = mk(3'd5, 16'h0001, 16'h0000, 16'h0010, 0, 16'h0001, 3'b000, 1'b0, 1);
`endif
    tbl[10] = mk(3'd2, 16'h0001, 16'h0000, 16'h0000, 0, 16'hFFFF, 3'b110, 1'b0, 1);
    tbl[11] = mk(3'd1, 16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0000, 3'b101, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("reset ctrl", {in_ready, out_valid, err}, 3'b100);
    check("reset unit_en", unit_en, 0);
    check("reset result_ccr", {result, ccr}, 0);
    check("reset unit_ops", {unit_rs, unit_rd, unit_shamt, unit_prev_flags}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Reset during step 2 of a 10-step shift aborts it and clears the CCR.
    check("rst_seq ccr_before", ccr, 3'b101);
    in_valid = 1'b1; opcode = 3'd5; rs_val = 16'h0001; rd_val = 16'h0; shamt = 16'd10;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_seq shifting", unit_en, 7'b0100000);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_seq after", {out_valid, in_ready, ccr, unit_en}, {2'b01, 3'b000, 7'b0});
    rst_n = 1'b1;
    model_ccr = 3'b000;
    @(negedge clk);
    check("rst_seq no_valid", out_valid, 0);
    run_instr(mk(3'd7, 16'h0F0F, 16'h5A5A, 16'h0003, 0, 16'h5A5A, 3'b000, 1'b1, 0), "rst_seq illegal");

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rsh = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
      v = ref_model(rop, 16'($urandom), 16'($urandom), rsh, model_ccr);
      v.hold = $urandom_range(0, 2);
      run_instr(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
